// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART buffer: a TX FIFO drained by a UART transmitter and an RX FIFO
// filled by a UART receiver, both exposed to the CPU through a 6-word register window.
//
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   addr, wd, we, re   - CPU byte address, store data, store strobe, load strobe
//   rdata              - CPU load data, combinational from current state
//   uart_tx_data/valid - byte at TX FIFO head and its valid flag
//   uart_tx_ready      - transmitter accepts the head byte this edge
//   uart_rx_data/valid - received byte and its single-cycle strobe
//   irq                - registered interrupt request
//
// Register map (offsets from BASE_ADDR, decoded on word address):
//   0x00 tx_not_full   0x04 rx_not_empty   0x08 TX data (write)
//   0x0C RX data (read pops)   0x10 STATUS (W1C ovf bits)   0x14 IRQ_EN
module uart_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        irq
);

  localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
  localparam int unsigned TxCntW = TxPtrW + 1;
  localparam int unsigned RxPtrW = $clog2(RX_DEPTH);
  localparam int unsigned RxCntW = RxPtrW + 1;

  // Address decode
  logic [31:0] off;
  logic        in_win;
  logic [2:0]  word;
  logic        sel_txd, sel_rxd, sel_status, sel_irqen;

  assign off        = addr - BASE_ADDR;
  assign in_win     = (off < 32'd24);
  assign word       = off[4:2];
  assign sel_txd    = in_win && (word == 3'd2);
  assign sel_rxd    = in_win && (word == 3'd3);
  assign sel_status = in_win && (word == 3'd4);
  assign sel_irqen  = in_win && (word == 3'd5);

  // State
  logic [7:0]        tx_mem [TX_DEPTH];
  logic [7:0]        rx_mem [RX_DEPTH];
  logic [TxPtrW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RxPtrW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
  logic              rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic [1:0]        irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop;
  logic rx_push, rx_pop, rx_drop;
  logic clr_rx_ovf, clr_tx_ovf;

  assign tx_full  = (tx_cnt_q == TxCntW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RxCntW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // Full is sampled before any same-edge pop, so a push into a full TX FIFO is always dropped.
  assign tx_push_req = we && sel_txd;
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = uart_tx_valid && uart_tx_ready;

  // A same-edge CPU pop frees a slot, so a receive into a full RX FIFO is still accepted.
  assign rx_pop  = re && sel_rxd && !rx_empty;
  assign rx_push = uart_rx_valid && (!rx_full || rx_pop);
  assign rx_drop = uart_rx_valid && rx_full && !rx_pop;

  assign clr_rx_ovf = we && sel_status && wd[0];
  assign clr_tx_ovf = we && sel_status && wd[1];

  always_comb begin
    tx_wptr_d = tx_wptr_q + TxPtrW'(tx_push);
    tx_rptr_d = tx_rptr_q + TxPtrW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + TxCntW'(tx_push) - TxCntW'(tx_pop);
    rx_wptr_d = rx_wptr_q + RxPtrW'(rx_push);
    rx_rptr_d = rx_rptr_q + RxPtrW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + RxCntW'(rx_push) - RxCntW'(rx_pop);
    // Set wins over a same-edge clear.
    rx_ovf_d  = (rx_ovf_q && !clr_rx_ovf) || rx_drop;
    tx_ovf_d  = (tx_ovf_q && !clr_tx_ovf) || (tx_push_req && tx_full);
    irq_en_d  = (we && sel_irqen) ? wd[1:0] : irq_en_q;
    irq_d     = (irq_en_q[0] && !rx_empty) || (irq_en_q[1] && tx_empty) || rx_ovf_q || tx_ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      irq_en_q  <= 2'b00;
      irq_q     <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  // Storage is not reset; pointers and counts alone define the FIFO contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= wd[7:0];
    if (rx_push) rx_mem[rx_wptr_q] <= uart_rx_data;
  end

  // Outputs
  assign uart_tx_valid = !tx_empty && !rst;
  assign uart_tx_data  = tx_mem[tx_rptr_q];
  assign irq           = irq_q;

  logic [7:0] tx_cnt8, rx_cnt8;
  assign tx_cnt8 = 8'(tx_cnt_q);
  assign rx_cnt8 = 8'(rx_cnt_q);

  always_comb begin
    rdata = '0;
    if (in_win) begin
      case (word)
        3'd0: rdata[0] = !tx_full;
        3'd1: rdata[0] = !rx_empty;
        3'd3: rdata[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
        3'd4: rdata = {8'b0, tx_cnt8, rx_cnt8, 6'b0, tx_ovf_q, rx_ovf_q};
        3'd5: rdata[1:0] = irq_en_q;
        default: rdata = '0;
      endcase
    end
  end

  logic unused;
  assign unused = ^{wd[31:8], off[1:0]};

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo with a scoreboard of expected values and
// queue models of both FIFOs.
module tb_uart_mmio_fifo;

  localparam logic [31:0] Base = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wd = '0;
  logic        we = 1'b0, re = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        irq;

  uart_mmio_fifo #(.BASE_ADDR(Base), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wd(wd), .we(we), .re(re), .rdata(rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic        tx_ovf_m = 1'b0, rx_ovf_m = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = sb.pop_front();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb.push_back(exp);
    check(tag, obs);
  endtask

  function automatic logic [31:0] status_m();
    return {8'b0, 8'(tx_q.size()), 8'(rx_q.size()), 6'b0, tx_ovf_m, rx_ovf_m};
  endfunction

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    addr = Base + off;
    wd = data;
    we = 1'b1;
    cyc();
    we = 1'b0;
    addr = '0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
    addr = Base + off;
    re = 1'b1;
    #1;
    expect_val(tag, rdata, exp);
    cyc();
    re = 1'b0;
    addr = '0;
  endtask

  task automatic wr_tx(input logic [7:0] b);
    wr(32'h08, {24'hABCDEF, b});
    if (tx_q.size() < 8) tx_q.push_back(b);
    else tx_ovf_m = 1'b1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_valid = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
    if (rx_q.size() < 8) rx_q.push_back(b);
    else rx_ovf_m = 1'b1;
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] exp;
    exp = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
    rd(32'h0C, exp, tag);
  endtask

  task automatic tx_drain(input int n);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      expect_val("tx_valid", {31'b0, uart_tx_valid}, 32'd1);
      expect_val("tx_data", {24'b0, uart_tx_data}, {24'b0, tx_q.pop_front()});
      cyc();
    end
    #1;
    expect_val("tx_valid_after_drain", {31'b0, uart_tx_valid}, 32'd0);
    uart_tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    rd(32'h00, 32'd1, "tx_not_full_rst");
    rd(32'h04, 32'd0, "rx_not_empty_rst");
    rd(32'h10, status_m(), "status_rst");
    rd(32'h14, 32'd0, "irq_en_rst");
    expect_val("irq_rst", {31'b0, irq}, 32'd0);
    expect_val("tx_valid_rst", {31'b0, uart_tx_valid}, 32'd0);

    // Three TX bytes held, then drained back to back
    wr_tx(8'h41);
    wr_tx(8'h42);
    wr_tx(8'h43);
    rd(32'h10, status_m(), "status_tx3");
    rd(32'h08, 32'd0, "txdata_reads_0");
    tx_drain(3);

    // TX overflow and W1C clear
    for (int i = 0; i < 8; i++) wr_tx(8'h60 + 8'(i));
    rd(32'h00, 32'd0, "tx_full_flag");
    wr_tx(8'h68);
    rd(32'h10, status_m(), "status_tx_ovf");
    wr(32'h10, 32'h1);
    rd(32'h10, status_m(), "status_wrong_bit_clear");
    wr(32'h10, 32'h2);
    tx_ovf_m = 1'b0;
    rd(32'h10, status_m(), "status_tx_ovf_clr");
    tx_drain(8);

    // RX fill, overflow, in-order drain, empty read
    for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i));
    rx_byte(8'hFF);
    rd(32'h10, status_m(), "status_rx_ovf");
    rd(32'h04, 32'd1, "rx_not_empty");
    for (int i = 0; i < 8; i++) rd_rx("rx_pop");
    rd_rx("rx_pop_empty");
    rd(32'h04, 32'd0, "rx_empty_flag");
    wr(32'h10, 32'h1);
    rx_ovf_m = 1'b0;
    rd(32'h10, status_m(), "status_rx_ovf_clr");

    // Full RX FIFO: CPU pop and receive on the same edge
    for (int i = 0; i < 8; i++) rx_byte(8'h20 + 8'(i));
    addr = Base + 32'h0C;
    re = 1'b1;
    uart_rx_data = 8'h28;
    uart_rx_valid = 1'b1;
    #1;
    expect_val("rx_pop_push_full", rdata, {24'b0, rx_q.pop_front()});
    rx_q.push_back(8'h28);
    cyc();
    re = 1'b0;
    uart_rx_valid = 1'b0;
    rd(32'h10, status_m(), "status_pop_push_full");
    for (int i = 0; i < 8; i++) rd_rx("rx_pop_after_full");

    // IRQ latency for RX data
    wr(32'h14, 32'h1);
    rd(32'h14, 32'd1, "irq_en_rb");
    expect_val("irq_idle", {31'b0, irq}, 32'd0);
    rx_byte(8'h55);
    expect_val("irq_edge1", {31'b0, irq}, 32'd0);
    cyc();
    expect_val("irq_edge2", {31'b0, irq}, 32'd1);
    rd_rx("irq_pop");
    expect_val("irq_after_pop_edge", {31'b0, irq}, 32'd1);
    cyc();
    expect_val("irq_cleared", {31'b0, irq}, 32'd0);

    // TX-empty interrupt
    wr(32'h14, 32'h2);
    expect_val("irq_txe_edge1", {31'b0, irq}, 32'd0);
    cyc();
    expect_val("irq_txe_edge2", {31'b0, irq}, 32'd1);
    wr(32'h14, 32'h0);
    cyc();
    expect_val("irq_txe_off", {31'b0, irq}, 32'd0);

    // Outside the window: reads 0, writes ignored
    rd(32'h18, 32'd0, "unmapped_read");
    addr = Base - 32'h4;
    #1;
    expect_val("below_window_read", rdata, 32'd0);
    wr(32'h1C, 32'h3);
    wr(32'h20, 32'h41);
    rd(32'h14, 32'd0, "unmapped_write_irqen");
    rd(32'h10, status_m(), "unmapped_write_status");

    // Reset with data queued
    wr_tx(8'h71);
    wr_tx(8'h72);
    wr_tx(8'h73);
    rx_byte(8'h81);
    rx_byte(8'h82);
    wr(32'h14, 32'h1);
    cyc();
    cyc();
    expect_val("irq_before_rst", {31'b0, irq}, 32'd1);
    rst = 1'b1;
    uart_tx_ready = 1'b1;
    #1;
    expect_val("tx_valid_in_rst", {31'b0, uart_tx_valid}, 32'd0);
    cyc();
    rst = 1'b0;
    uart_tx_ready = 1'b0;
    tx_q.delete();
    rx_q.delete();
    expect_val("irq_after_rst", {31'b0, irq}, 32'd0);
    expect_val("tx_valid_after_rst", {31'b0, uart_tx_valid}, 32'd0);
    rd(32'h10, status_m(), "status_after_rst");
    rd(32'h14, 32'd0, "irq_en_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
